// File: rtl/connect4_turn_controller_if.sv
// Connect-4 turn controller bundle: drop requests in, board state and status out.
// Carries only wires; the controller registers every output it drives.
// The master drives requests; the slave (the controller) drives status.
interface connect4_turn_controller_if;
  logic        new_game;
  logic        drop_req;
  logic [3:0]  column_sel;
  logic [15:0] gameboard_out;
  logic [15:0] player_cells;
  logic        current_player;
  logic        busy;
  logic        drop_ack;
  logic        drop_reject;
  logic        game_over;
  logic [1:0]  winner;

  modport master (
    output new_game, drop_req, column_sel,
    input  gameboard_out, player_cells, current_player, busy,
    input  drop_ack, drop_reject, game_over, winner
  );

  modport slave (
    input  new_game, drop_req, column_sel,
    output gameboard_out, player_cells, current_player, busy,
    output drop_ack, drop_reject, game_over, winner
  );
endinterface

// File: rtl/connect4_turn_controller.sv
// 4x4 Connect-4 turn controller: validates a column drop, places the token, scores the board.
// Latency: drop_ack 4 edges after drop_req; drop_reject 2 edges after drop_req.
// Backpressure: drop_req is ignored while busy; new_game overrides everything.
module connect4_turn_controller #(
  parameter logic FIRST_PLAYER = 1'b0
) (
  input logic clk,
  input logic rst,
  connect4_turn_controller_if.slave bus
);

  typedef enum logic [2:0] {IDLE, CHECK, PLACE, EVAL, OVER} state_t;

  // Lines that win: 4 rows, 4 columns, main diagonal, anti-diagonal.
  localparam logic [15:0] LINE_MASK [10] = '{
    16'h000F, 16'h00F0, 16'h0F00, 16'hF000,
    16'h1111, 16'h2222, 16'h4444, 16'h8888,
    16'h8421, 16'h1248
  };

  state_t      state_q, state_d;
  logic [3:0]  col_q, col_d;
  logic [15:0] board_q, board_d;
  logic [15:0] cells_q, cells_d;
  logic [2:0]  height_q [4];
  logic [2:0]  height_d [4];
  logic        player_q, player_d;
  logic [1:0]  winner_q, winner_d;
  logic        over_q, over_d;
  logic        ack_q, ack_d;
  logic        rej_q, rej_d;
  logic        busy;

  logic        col_onehot;
  logic [1:0]  col_idx;
  logic [2:0]  tgt_h;
  logic [3:0]  place_bit;
  logic        drop_bad;
  logic [15:0] owner;
  logic        win_found;
  logic        board_full;

  // Decode the latched column select and look up the target column height.
  always_comb begin
    col_onehot = (col_q != 4'd0) && ((col_q & (col_q - 4'd1)) == 4'd0);
    case (col_q)
      4'b0010: col_idx = 2'd1;
      4'b0100: col_idx = 2'd2;
      4'b1000: col_idx = 2'd3;
      default: col_idx = 2'd0;
    endcase
    tgt_h     = height_q[col_idx];
    place_bit = {tgt_h[1:0], col_idx};
    drop_bad  = !col_onehot || (tgt_h >= 3'd4);
  end

  // Score the board for the player who just moved.
  always_comb begin
    owner      = player_q ? (board_q & cells_q) : (board_q & ~cells_q);
    board_full = &board_q;
    win_found  = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if ((owner & LINE_MASK[i]) == LINE_MASK[i]) win_found = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; new_game wins over any state.
  always_comb begin
    state_d = state_q;
    if (bus.new_game) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (bus.drop_req) state_d = CHECK;
        CHECK:   state_d = drop_bad ? IDLE : PLACE;
        PLACE:   state_d = EVAL;
        EVAL:    state_d = (win_found || board_full) ? OVER : IDLE;
        OVER:    state_d = OVER;
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM-decoded output.
  always_comb begin
    busy = (state_q != IDLE);
  end

  // Board and status next-state: placement at PLACE, scoring at EVAL.
  always_comb begin
    col_d    = col_q;
    board_d  = board_q;
    cells_d  = cells_q;
    height_d = height_q;
    player_d = player_q;
    winner_d = winner_q;
    over_d   = over_q;
    ack_d    = 1'b0;
    rej_d    = 1'b0;
    if (bus.new_game) begin
      col_d    = 4'd0;
      board_d  = 16'd0;
      cells_d  = 16'd0;
      for (int i = 0; i < 4; i++) height_d[i] = 3'd0;
      player_d = FIRST_PLAYER;
      winner_d = 2'b00;
      over_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.drop_req) col_d = bus.column_sel;
        CHECK: rej_d = drop_bad;
        PLACE: begin
          if (tgt_h < 3'd4) begin
            board_d[place_bit]  = 1'b1;
            cells_d[place_bit]  = player_q;
            height_d[col_idx]   = tgt_h + 3'd1;
          end
        end
        EVAL: begin
          ack_d = 1'b1;
          if (win_found) begin
            over_d   = 1'b1;
            winner_d = player_q ? 2'b10 : 2'b01;
          end else if (board_full) begin
            over_d   = 1'b1;
            winner_d = 2'b11;
          end else begin
            player_d = ~player_q;
          end
        end
        default: ;
      endcase
    end
  end

  // Board and status registers; reset clears everything immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q    <= 4'd0;
      board_q  <= 16'd0;
      cells_q  <= 16'd0;
      for (int i = 0; i < 4; i++) height_q[i] <= 3'd0;
      player_q <= FIRST_PLAYER;
      winner_q <= 2'b00;
      over_q   <= 1'b0;
      ack_q    <= 1'b0;
      rej_q    <= 1'b0;
    end else begin
      col_q    <= col_d;
      board_q  <= board_d;
      cells_q  <= cells_d;
      for (int i = 0; i < 4; i++) height_q[i] <= height_d[i];
      player_q <= player_d;
      winner_q <= winner_d;
      over_q   <= over_d;
      ack_q    <= ack_d;
      rej_q    <= rej_d;
    end
  end

  assign bus.gameboard_out  = board_q;
  assign bus.player_cells   = cells_q;
  assign bus.current_player = player_q;
  assign bus.busy           = busy;
  assign bus.drop_ack       = ack_q;
  assign bus.drop_reject    = rej_q;
  assign bus.game_over      = over_q;
  assign bus.winner         = winner_q;

endmodule

// File: tb/tb_connect4_turn_controller.sv
// Bench for the Connect-4 turn controller: scoreboard of expected drop outcomes.
// Expected results come from a coordinate-based game model in the bench.
// Each scenario task drives drops and compares outcomes when ack/reject appears.
module tb_connect4_turn_controller;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  connect4_turn_controller_if bus();

  connect4_turn_controller #(.FIRST_PLAYER(1'b0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit          is_ack;
    logic [15:0] board;
    logic [15:0] cells;
    logic        player;
    logic [1:0]  winner;
    logic        over;
  } exp_t;

  exp_t sb[$];

  int          m_h [4];
  logic [15:0] m_board;
  logic [15:0] m_cells;
  logic        m_player;
  logic [1:0]  m_winner;
  logic        m_over;

  task automatic model_clear();
    for (int i = 0; i < 4; i++) m_h[i] = 0;
    m_board  = 16'd0;
    m_cells  = 16'd0;
    m_player = 1'b0;
    m_winner = 2'b00;
    m_over   = 1'b0;
    sb.delete();
  endtask

  function automatic bit m_owned(int r, int c);
    return m_board[r*4+c] && (m_cells[r*4+c] == m_player);
  endfunction

  function automatic bit model_win();
    bit all;
    for (int r = 0; r < 4; r++) begin
      all = 1'b1;
      for (int c = 0; c < 4; c++) all = all & m_owned(r, c);
      if (all) return 1'b1;
    end
    for (int c = 0; c < 4; c++) begin
      all = 1'b1;
      for (int r = 0; r < 4; r++) all = all & m_owned(r, c);
      if (all) return 1'b1;
    end
    all = 1'b1;
    for (int i = 0; i < 4; i++) all = all & m_owned(i, i);
    if (all) return 1'b1;
    all = 1'b1;
    for (int i = 0; i < 4; i++) all = all & m_owned(i, 3 - i);
    return all;
  endfunction

  task automatic model_predict(input logic [3:0] sel, output bit responds);
    exp_t e;
    int c;
    int n;
    int idx;
    responds = 1'b0;
    if (m_over) return;
    responds = 1'b1;
    n = 0;
    c = 0;
    for (int i = 0; i < 4; i++) if (sel[i]) begin n++; c = i; end
    if (n != 1 || m_h[c] == 4) begin
      e.is_ack = 1'b0;
    end else begin
      e.is_ack = 1'b1;
      idx = m_h[c] * 4 + c;
      m_board[idx] = 1'b1;
      m_cells[idx] = m_player;
      m_h[c]++;
      if (model_win()) begin
        m_over = 1'b1;
        m_winner = m_player ? 2'b10 : 2'b01;
      end else if (m_board == 16'hFFFF) begin
        m_over = 1'b1;
        m_winner = 2'b11;
      end else begin
        m_player = ~m_player;
      end
    end
    e.board  = m_board;
    e.cells  = m_cells;
    e.player = m_player;
    e.winner = m_winner;
    e.over   = m_over;
    sb.push_back(e);
  endtask

  // Drive one drop, then pop the scoreboard when the DUT answers.
  task automatic run_drop(input logic [3:0] sel, input bit poke, input string tag);
    bit resp;
    bit seen;
    int lat;
    exp_t e;
    model_predict(sel, resp);
    @(posedge clk); #1;
    bus.drop_req = 1'b1;
    bus.column_sel = sel;
    @(posedge clk); #1;
    bus.drop_req = poke;
    bus.column_sel = 4'($urandom);
    if (poke && resp) begin
      total++;
      if (bus.busy !== 1'b1) begin
        bad++;
        $display("FAIL %s busy_after_accept: got %0b want 1", tag, bus.busy);
      end
    end
    seen = 1'b0;
    lat = 0;
    for (int k = 1; k <= 8 && !seen; k++) begin
      @(posedge clk); #1;
      if (k >= 2) bus.drop_req = 1'b0;
      if (bus.drop_ack || bus.drop_reject) begin
        seen = 1'b1;
        lat = k;
      end
    end
    bus.drop_req = 1'b0;
    total++;
    if (resp) begin
      if (!seen) begin
        bad++;
        $display("FAIL %s timeout: got no ack/reject want response", tag);
        if (sb.size() > 0) void'(sb.pop_front());
      end else begin
        e = sb.pop_front();
        if (bus.drop_ack !== e.is_ack || bus.drop_reject !== !e.is_ack) begin
          bad++;
          $display("FAIL %s kind: got ack=%0b rej=%0b want ack=%0b", tag, bus.drop_ack, bus.drop_reject, e.is_ack);
        end
        total++;
        if (lat !== (e.is_ack ? 3 : 1)) begin
          bad++;
          $display("FAIL %s latency: got %0d want %0d", tag, lat, e.is_ack ? 3 : 1);
        end
        total++;
        if (bus.gameboard_out !== e.board || bus.player_cells !== e.cells) begin
          bad++;
          $display("FAIL %s board: got %h/%h want %h/%h", tag, bus.gameboard_out, bus.player_cells, e.board, e.cells);
        end
        total++;
        if (bus.current_player !== e.player || bus.winner !== e.winner || bus.game_over !== e.over) begin
          bad++;
          $display("FAIL %s status: got p=%0b w=%0b o=%0b want p=%0b w=%0b o=%0b", tag,
                   bus.current_player, bus.winner, bus.game_over, e.player, e.winner, e.over);
        end
        @(posedge clk); #1;
        total++;
        if (bus.drop_ack !== 1'b0 || bus.drop_reject !== 1'b0) begin
          bad++;
          $display("FAIL %s pulse_width: got ack=%0b rej=%0b want 0/0", tag, bus.drop_ack, bus.drop_reject);
        end
      end
    end else begin
      if (seen) begin
        bad++;
        $display("FAIL %s ignored: got ack=%0b rej=%0b want none", tag, bus.drop_ack, bus.drop_reject);
      end
      total++;
      if (bus.gameboard_out !== m_board) begin
        bad++;
        $display("FAIL %s ignored_board: got %h want %h", tag, bus.gameboard_out, m_board);
      end
    end
  endtask

  task automatic pulse_new_game();
    @(posedge clk); #1;
    bus.new_game = 1'b1;
    @(posedge clk); #1;
    bus.new_game = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.new_game = 1'b0;
    bus.drop_req = 1'b0;
    bus.column_sel = 4'd0;
    #2;
    total++;
    if (bus.gameboard_out !== 16'd0 || bus.player_cells !== 16'd0) begin
      bad++;
      $display("FAIL reset_board: got %h/%h want 0000/0000", bus.gameboard_out, bus.player_cells);
    end
    total++;
    if (bus.current_player !== 1'b0 || bus.busy !== 1'b0 || bus.drop_ack !== 1'b0 ||
        bus.drop_reject !== 1'b0 || bus.game_over !== 1'b0 || bus.winner !== 2'b00) begin
      bad++;
      $display("FAIL reset_status: got p=%0b b=%0b a=%0b r=%0b o=%0b w=%0b want all 0",
               bus.current_player, bus.busy, bus.drop_ack, bus.drop_reject, bus.game_over, bus.winner);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    model_clear();
  endtask

  task automatic test_first_drop();
    run_drop(4'b0001, 1'b0, "first_drop");
    total++;
    if (bus.gameboard_out !== 16'h0001 || bus.player_cells !== 16'h0000 || bus.current_player !== 1'b1) begin
      bad++;
      $display("FAIL first_drop_const: got %h/%h p=%0b want 0001/0000 p=1",
               bus.gameboard_out, bus.player_cells, bus.current_player);
    end
  endtask

  task automatic test_column_full();
    pulse_new_game();
    for (int i = 0; i < 5; i++) run_drop(4'b0010, 1'b0, "col_full");
    total++;
    if (bus.gameboard_out !== 16'h2222 || bus.player_cells !== 16'h2020) begin
      bad++;
      $display("FAIL col_full_const: got %h/%h want 2222/2020", bus.gameboard_out, bus.player_cells);
    end
  endtask

  task automatic test_bad_select();
    logic [15:0] b0;
    logic p0;
    b0 = bus.gameboard_out;
    p0 = bus.current_player;
    run_drop(4'b0110, 1'b0, "sel_0110");
    run_drop(4'b0000, 1'b0, "sel_0000");
    run_drop(4'b1011, 1'b0, "sel_1011");
    total++;
    if (bus.gameboard_out !== b0 || bus.current_player !== p0) begin
      bad++;
      $display("FAIL bad_sel_unchanged: got %h p=%0b want %h p=%0b", bus.gameboard_out, bus.current_player, b0, p0);
    end
  endtask

  task automatic test_win_and_over();
    logic [3:0] seq [7];
    seq = '{4'b0001, 4'b0001, 4'b0010, 4'b0001, 4'b0100, 4'b0001, 4'b1000};
    pulse_new_game();
    foreach (seq[i]) run_drop(seq[i], 1'b0, "win_seq");
    total++;
    if (bus.winner !== 2'b01 || bus.game_over !== 1'b1 || (bus.gameboard_out & 16'h000F) !== 16'h000F) begin
      bad++;
      $display("FAIL win_const: got w=%0b o=%0b b=%h want w=01 o=1 row0 set", bus.winner, bus.game_over, bus.gameboard_out);
    end
    run_drop(4'b0100, 1'b0, "drop_in_over");
    total++;
    if (bus.busy !== 1'b1 || bus.winner !== 2'b01) begin
      bad++;
      $display("FAIL over_hold: got b=%0b w=%0b want b=1 w=01", bus.busy, bus.winner);
    end
    @(posedge clk); #1;
    bus.new_game = 1'b1;
    @(posedge clk); #1;
    bus.new_game = 1'b0;
    model_clear();
    total++;
    if (bus.gameboard_out !== 16'd0 || bus.player_cells !== 16'd0 || bus.current_player !== 1'b0 ||
        bus.busy !== 1'b0 || bus.game_over !== 1'b0 || bus.winner !== 2'b00 ||
        bus.drop_ack !== 1'b0 || bus.drop_reject !== 1'b0) begin
      bad++;
      $display("FAIL new_game_in_over: got b=%h c=%h p=%0b busy=%0b o=%0b w=%0b want all 0",
               bus.gameboard_out, bus.player_cells, bus.current_player, bus.busy, bus.game_over, bus.winner);
    end
  endtask

  task automatic test_busy_ignore();
    run_drop(4'b0100, 1'b1, "busy_ignore");
    total++;
    if (bus.gameboard_out !== 16'h0004) begin
      bad++;
      $display("FAIL busy_ignore_const: got %h want 0004", bus.gameboard_out);
    end
  endtask

  task automatic test_new_game_with_drop();
    bit seen;
    run_drop(4'b0001, 1'b0, "ngd_pre");
    @(posedge clk); #1;
    bus.new_game = 1'b1;
    bus.drop_req = 1'b1;
    bus.column_sel = 4'b0001;
    @(posedge clk); #1;
    bus.new_game = 1'b0;
    bus.drop_req = 1'b0;
    model_clear();
    total++;
    if (bus.gameboard_out !== 16'd0 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL ngd_clear: got b=%h busy=%0b want 0000 busy=0", bus.gameboard_out, bus.busy);
    end
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (bus.drop_ack || bus.drop_reject || bus.gameboard_out != 16'd0) seen = 1'b1;
    end
    total++;
    if (seen) begin
      bad++;
      $display("FAIL ngd_discard: got activity=1 want 0");
    end
  endtask

  task automatic test_draw();
    int cols [16];
    cols = '{0, 2, 1, 3, 2, 0, 3, 1, 0, 2, 1, 3, 2, 0, 3, 1};
    pulse_new_game();
    foreach (cols[i]) run_drop(4'b0001 << cols[i], 1'b0, "draw_seq");
    total++;
    if (bus.winner !== 2'b11 || bus.game_over !== 1'b1 ||
        bus.gameboard_out !== 16'hFFFF || bus.player_cells !== 16'h3C3C) begin
      bad++;
      $display("FAIL draw_const: got w=%0b o=%0b b=%h c=%h want w=11 o=1 FFFF 3C3C",
               bus.winner, bus.game_over, bus.gameboard_out, bus.player_cells);
    end
  endtask

  task automatic test_reset_mid_place();
    bit resp;
    bit seen;
    exp_t e;
    pulse_new_game();
    run_drop(4'b0001, 1'b0, "rmp_pre0");
    run_drop(4'b0010, 1'b0, "rmp_pre1");
    @(posedge clk); #1;
    bus.drop_req = 1'b1;
    bus.column_sel = 4'b0100;
    @(posedge clk); #1;
    bus.drop_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    total++;
    if (bus.gameboard_out !== 16'd0 || bus.player_cells !== 16'd0 ||
        bus.busy !== 1'b0 || bus.current_player !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid_place: got b=%h c=%h busy=%0b p=%0b want 0 0 0 0",
               bus.gameboard_out, bus.player_cells, bus.busy, bus.current_player);
    end
    model_clear();
    model_predict(4'b1000, resp);
    bus.drop_req = 1'b1;
    bus.column_sel = 4'b1000;
    #2;
    rst = 1'b0;
    @(posedge clk); #1;
    bus.drop_req = 1'b0;
    total++;
    if (bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL first_edge_accept: got busy=%0b want 1", bus.busy);
    end
    seen = 1'b0;
    for (int k = 0; k < 6 && !seen; k++) begin
      @(posedge clk); #1;
      if (bus.drop_ack) seen = 1'b1;
    end
    total++;
    if (!seen || !resp) begin
      bad++;
      $display("FAIL post_rst_drop: got ack=%0b want 1", seen);
      if (sb.size() > 0) void'(sb.pop_front());
    end else begin
      e = sb.pop_front();
      total++;
      if (bus.gameboard_out !== e.board || bus.gameboard_out !== 16'h0008) begin
        bad++;
        $display("FAIL post_rst_board: got %h want %h", bus.gameboard_out, e.board);
      end
    end
  endtask

  task automatic test_back_to_back();
    pulse_new_game();
    for (int i = 0; i < 10; i++) run_drop(4'($urandom_range(0, 15)), 1'b0, "b2b");
  endtask

  initial begin
    test_reset();
    test_first_drop();
    test_column_full();
    test_bad_select();
    test_win_and_over();
    test_busy_ignore();
    test_new_game_with_drop();
    test_draw();
    test_reset_mid_place();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/connect4_turn_controller.md
CONNECT4_TURN_CONTROLLER -- requirements
Module: connect4_turn_controller

Interface
REQ-001 Parameter FIRST_PLAYER, default 0: player who moves first after reset or new_game (0 = P0, 1 = P1).
REQ-002 clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 new_game  input  1  synchronous one-cycle clear request.
REQ-005 drop_req  input  1  one-cycle pulse from the debounced button-press detector requesting a token drop.
REQ-006 column_sel  input  4  one-hot column select (bit c = column c), sampled only with drop_req.
REQ-007 gameboard_out  output  16  occupancy map; bit (row*4+col) = 1 when the cell is filled; row 0 is the bottom row.
REQ-008 player_cells  output  16  owner map; bit = 1 when the cell belongs to P1; bits of empty cells are 0.
REQ-009 current_player  output  1  player whose turn it is.
REQ-010 busy  output  1  high whenever the FSM is not in IDLE.
REQ-011 drop_ack  output  1  one-cycle pulse marking a completed legal drop.
REQ-012 drop_reject  output  1  one-cycle pulse marking an illegal drop (full column or a non-one-hot select).
REQ-013 game_over  output  1  level; high from game end until new_game or rst.
REQ-014 winner  output  2  result code: 00 none, 01 P0, 10 P1, 11 draw.

Function
REQ-015 FSM states SHALL be IDLE, CHECK, PLACE, EVAL and OVER.
REQ-016 Edge E0: drop_req high in IDLE latches column_sel and moves IDLE -> CHECK; drop_req in any other state SHALL be ignored with no ack or reject.
REQ-017 Edge E1 (CHECK): a column_sel that is not exactly one-hot, or a target column of height 4, SHALL return the FSM to IDLE with drop_reject high for the following cycle; otherwise the FSM moves CHECK -> PLACE.
REQ-018 Edge E2 (PLACE): the block SHALL set gameboard_out bit (h*4+c), where h = current height of column c, and set player_cells at that bit to current_player.
REQ-019 Edge E2 (PLACE): the height of column c SHALL increment by 1, and the FSM moves PLACE -> EVAL.
REQ-020 Per-column height counters SHALL be 3 bits wide, saturate at 4 and never wrap.
REQ-021 Edge E3 (EVAL): the block SHALL check all 10 lines (4 rows, 4 columns, 2 diagonals) for full ownership by current_player.
REQ-022 EVAL, win found: FSM -> OVER, winner = 01 or 10, game_over = 1, current_player unchanged.
REQ-023 EVAL, no win and all 16 cells filled: FSM -> OVER, winner = 11, game_over = 1.
REQ-024 EVAL, otherwise: current_player toggles and the FSM returns to IDLE.
REQ-025 drop_ack SHALL be high for exactly the cycle after E3 in every EVAL outcome, so a legal drop completes with latency 4 edges from drop_req.
REQ-026 All board-related outputs SHALL be registered and SHALL change only at E2 or E3.
REQ-027 new_game SHALL take priority over every state and input: on the next edge the FSM enters IDLE, both maps clear, heights clear, current_player = FIRST_PLAYER, winner = 00, game_over = 0, and no ack or reject pulses.
REQ-028 When new_game and drop_req are high in the same cycle, the drop SHALL be discarded.
REQ-029 OVER SHALL hold all outputs stable until new_game or rst.
REQ-030 busy SHALL be high in CHECK, PLACE, EVAL and OVER.

Reset
REQ-031 rst high SHALL immediately, without a clock edge, force the FSM to IDLE, gameboard_out = 0, player_cells = 0, all heights = 0, current_player = FIRST_PLAYER, drop_ack = 0, drop_reject = 0, game_over = 0 and winner = 00.
REQ-032 rst asserted mid-operation (CHECK/PLACE/EVAL) SHALL abort the drop with no partial board update surviving.
REQ-033 After rst deasserts, the first rising edge SHALL already accept drop_req.

Verification
REQ-034 Reset, then drop col0 (column_sel = 0001) -> 4 edges later drop_ack = 1, gameboard_out = 0x0001, player_cells = 0x0000, current_player = 1.
REQ-035 Five drops into col1 alternating players -> drops 1-4 fill bits 1, 5, 9, 13 (gameboard_out = 0x2222, player_cells = 0x2020); drop 5 gives drop_reject with the board unchanged.
REQ-036 column_sel = 0110 with drop_req -> drop_reject after E1, no board change, current_player unchanged.
REQ-037 P0 in cols 0,1,2,3 interleaved with P1 in col0 -> after P0's fourth drop: winner = 01, game_over = 1, row-0 bits 0x000F set; a further drop_req gets no ack or reject.
REQ-038 drop_req pulsed while busy = 1 -> ignored; new_game in OVER -> all outputs return to their reset values next cycle.
REQ-039 A fill of all 16 cells with no line complete -> winner = 11 on the 16th drop; rst asserted during PLACE -> gameboard_out = 0 without a clock edge.
